logic_unit_arbiter: RTL and testbench

- Shares one registered bitwise logic unit (NOT/AND/OR/XOR) between NREQ requesters.
- Requesters use a valid/ready request handshake. The single response channel is tagged with the requester ID.
- Grants are round-robin.
- Sits between lab gate-level datapath clients and the shared logic unit. Sequences each operation through grant, execute and respond.

---
 rtl/logic_unit_arbiter_pkg.sv | 18 +
 rtl/logic_unit_arbiter_rr_arbiter.sv | 32 +++
 rtl/logic_unit_arbiter.sv | 128 ++++++++++++
 tb/tb_logic_unit_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_arbiter_pkg.sv
// Shared constants for the logic unit arbiter: opcodes, FSM states, default sizes.
package logic_unit_arbiter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_NREQ  = 4;

    localparam logic [1:0] OP_NOT = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

endpackage

// File: rtl/logic_unit_arbiter_rr_arbiter.sv
// Combinational round-robin grant: search starts one past last_grant and wraps.
module rr_arbiter
    import logic_unit_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = DEFAULT_NREQ,
    parameter int unsigned ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [ID_W-1:0] last_grant,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_idx,
    output logic            grant_any
);

    logic [ID_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = ID_W'((32'(last_grant) + k) % NREQ);
            if (!grant_any && req_valid[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                grant_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin shared bitwise logic unit with a tagged response channel.
// Optional completed-operation counter enabled by LOGIC_ARB_STATS_EN.
module logic_unit_arbiter
    import logic_unit_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned NREQ  = DEFAULT_NREQ
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [2*NREQ-1:0]          req_op,
    input  logic [WIDTH*NREQ-1:0]      req_a,
    input  logic [WIDTH*NREQ-1:0]      req_b,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NREQ)-1:0]    rsp_id,
    output logic [WIDTH-1:0]           rsp_data
`ifdef LOGIC_ARB_STATS_EN
    ,
    output logic [15:0]                op_count
`endif
);

    localparam int unsigned ID_W = $clog2(NREQ);

    state_t             state;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [ID_W-1:0]    id_q;
    logic [ID_W-1:0]    last_grant;

    logic [NREQ-1:0]    grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_any;

    logic [1:0]         op_arr [NREQ];
    logic [WIDTH-1:0]   a_arr  [NREQ];
    logic [WIDTH-1:0]   b_arr  [NREQ];

    // Unpack the flat request buses so the winner can be selected by index.
    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign op_arr[i] = req_op[2*i +: 2];
        assign a_arr[i]  = req_a[WIDTH*i +: WIDTH];
        assign b_arr[i]  = req_b[WIDTH*i +: WIDTH];
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_rr_arbiter (
        .req_valid  (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_any  (grant_any)
    );

    assign req_ready = (state == IDLE) ? grant : '0;

    function automatic logic [WIDTH-1:0] logic_fn(
        input logic [1:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        case (op)
            OP_NOT:  return ~a;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            default: return a ^ b;
        endcase
    endfunction

    // Grant -> execute -> respond sequencer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= '0;
            last_grant <= ID_W'(NREQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        op_q       <= op_arr[grant_idx];
                        a_q        <= a_arr[grant_idx];
                        b_q        <= b_arr[grant_idx];
                        id_q       <= grant_idx;
                        last_grant <= grant_idx;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= logic_fn(op_q, a_q, b_q);
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LOGIC_ARB_STATS_EN
    // Counts response handshakes; wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count <= '0;
        end else if (state == RESP && rsp_valid && rsp_ready) begin
            op_count <= op_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: directed scenarios plus randomized
// traffic compared against a round-robin / bitwise reference model.
module tb_logic_unit_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [2*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_a;
    logic [WIDTH*NREQ-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [1:0]            rsp_id;
    logic [WIDTH-1:0]      rsp_data;
`ifdef LOGIC_ARB_STATS_EN
    logic [15:0]           op_count;
`endif

    int errors = 0;
    int checks = 0;
    int model_last = NREQ - 1;
    int exp_count = 0;

    always #5 clk = ~clk;

    logic_unit_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
`ifdef LOGIC_ARB_STATS_EN
        ,
        .op_count  (op_count)
`endif
    );

    // Reference: first valid requester found after the last winner, wrapping.
    function automatic int exp_winner(input logic [NREQ-1:0] m, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (m[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [WIDTH-1:0] exp_fn(input logic [1:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        case (op)
            2'd0:    return ~a;
            2'd1:    return a & b;
            2'd2:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
        req_op = '0; req_a = '0; req_b = '0;
        tick(); tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
        checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL reset_rsp_data got=%h exp=00", rsp_data); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
`ifdef LOGIC_ARB_STATS_EN
        checks++; if (op_count !== 16'd0) begin errors++; $display("FAIL reset_op_count got=%0d exp=0", op_count); end
`endif
        rst = 1'b0; model_last = NREQ - 1; exp_count = 0;
        tick();
    endtask

    task automatic test_not();
        req_op = 8'($urandom); req_op[1:0] = 2'b00;
        req_a = $urandom; req_a[7:0] = 8'hA5;
        req_b = $urandom;
        req_valid = 4'b0001; rsp_ready = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL not_grant got=%b exp=0001", req_ready); end
        tick();
        req_valid = '0;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL not_ready_pulse got=%b exp=0000", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL not_early_valid got=%b exp=0", rsp_valid); end
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 8'h5A) begin
            errors++; $display("FAIL not_rsp got v=%b id=%0d d=%h exp v=1 id=0 d=5a", rsp_valid, rsp_id, rsp_data); end
        rsp_ready = 1'b1;
        tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL not_rsp_drop got=%b exp=0", rsp_valid); end
        model_last = 0; exp_count++; rsp_ready = 1'b0;
    endtask

    task automatic test_ops();
        logic [1:0]       ops  [3];
        logic [WIDTH-1:0] as   [3];
        logic [WIDTH-1:0] bs   [3];
        logic [WIDTH-1:0] exps [3];
        ops  = '{2'b01, 2'b10, 2'b11};
        as   = '{8'hA5, 8'hA0, 8'hFF};
        bs   = '{8'h0F, 8'h05, 8'h0F};
        exps = '{8'h05, 8'hA5, 8'hF0};
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_op = 8'($urandom); req_op[5:4] = ops[i];
            req_a = $urandom; req_a[23:16] = as[i];
            req_b = $urandom; req_b[23:16] = bs[i];
            req_valid = 4'b0100;
            #1;
            checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL ops%0d_grant got=%b exp=0100", i, req_ready); end
            tick();
            req_valid = '0;
            tick();
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== exps[i]) begin
                errors++; $display("FAIL ops%0d_rsp got v=%b id=%0d d=%h exp v=1 id=2 d=%h", i, rsp_valid, rsp_id, rsp_data, exps[i]); end
            tick();
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL ops%0d_drop got=%b exp=0", i, rsp_valid); end
            model_last = 2; exp_count++;
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_round_robin();
        int order [5];
        logic [WIDTH-1:0] eres;
        order = '{0, 1, 2, 3, 0};
        rst = 1'b1; tick(); rst = 1'b0; model_last = NREQ - 1; exp_count = 0;
        rsp_ready = 1'b1; req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            req_op = 8'($urandom); req_a = $urandom; req_b = $urandom;
            #1;
            checks++; if (req_ready !== 4'(1 << order[i])) begin
                errors++; $display("FAIL rr%0d_grant got=%b exp_idx=%0d", i, req_ready, order[i]); end
            eres = exp_fn(req_op[2*order[i] +: 2], req_a[WIDTH*order[i] +: WIDTH], req_b[WIDTH*order[i] +: WIDTH]);
            tick();
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rr%0d_exec_ready got=%b exp=0000", i, req_ready); end
            tick();
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(order[i]) || rsp_data !== eres) begin
                errors++; $display("FAIL rr%0d_rsp got v=%b id=%0d d=%h exp v=1 id=%0d d=%h", i, rsp_valid, rsp_id, rsp_data, order[i], eres); end
            tick();
            model_last = order[i]; exp_count++;
        end
        req_valid = '0; rsp_ready = 1'b0;
    endtask

    task automatic test_hold();
        logic [NREQ-1:0]  m;
        logic [WIDTH-1:0] eres;
        int w;
        m = 4'b1010;
        req_op = 8'($urandom); req_a = $urandom; req_b = $urandom;
        req_valid = m; rsp_ready = 1'b0;
        w = exp_winner(m, model_last);
        #1;
        checks++; if (req_ready !== 4'(1 << w)) begin errors++; $display("FAIL hold_grant got=%b exp_idx=%0d", req_ready, w); end
        eres = exp_fn(req_op[2*w +: 2], req_a[WIDTH*w +: WIDTH], req_b[WIDTH*w +: WIDTH]);
        model_last = w;
        tick();
        req_op = 8'($urandom); req_a = $urandom; req_b = $urandom;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(w) || rsp_data !== eres || req_ready !== 4'b0000) begin
                errors++; $display("FAIL hold%0d got v=%b id=%0d d=%h rdy=%b exp v=1 id=%0d d=%h rdy=0000",
                                   i, rsp_valid, rsp_id, rsp_data, req_ready, w, eres); end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        exp_count++;
        checks++; if (rsp_valid !== 1'b0 || rsp_data !== eres) begin
            errors++; $display("FAIL hold_release got v=%b d=%h exp v=0 d=%h", rsp_valid, rsp_data, eres); end
        w = exp_winner(m, model_last);
        checks++; if (req_ready !== 4'(1 << w)) begin errors++; $display("FAIL hold_next_grant got=%b exp_idx=%0d", req_ready, w); end
        req_valid = '0; rsp_ready = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL drop_ready got=%b exp=0000", req_ready); end
        tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL drop_no_grant got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_abort();
        logic [NREQ-1:0] m;
        int w;
        m = 4'b0100;
        req_op = 8'($urandom); req_a = $urandom; req_b = $urandom;
        req_valid = m; rsp_ready = 1'b1;
        w = exp_winner(m, model_last);
        #1;
        checks++; if (req_ready !== 4'(1 << w)) begin errors++; $display("FAIL abort_grant got=%b exp_idx=%0d", req_ready, w); end
        tick();
        req_valid = '0; rst = 1'b1;
        #1;
        checks++; if (rsp_valid !== 1'b0 || rsp_data !== 8'h00 || rsp_id !== 2'd0) begin
            errors++; $display("FAIL abort_async got v=%b id=%0d d=%h exp v=0 id=0 d=00", rsp_valid, rsp_id, rsp_data); end
        tick();
        rst = 1'b0; model_last = NREQ - 1; exp_count = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_no_rsp%0d got=%b exp=0", i, rsp_valid); end
        end
`ifdef LOGIC_ARB_STATS_EN
        checks++; if (op_count !== 16'd0) begin errors++; $display("FAIL abort_op_count got=%0d exp=0", op_count); end
`endif
        req_valid = 4'b1111;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL abort_first_grant got=%b exp=0001", req_ready); end
        tick(); req_valid = '0; tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin
            errors++; $display("FAIL abort_after_rsp got v=%b id=%0d exp v=1 id=0", rsp_valid, rsp_id); end
        tick();
        model_last = 0; exp_count++; rsp_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [NREQ-1:0]  m;
        logic [WIDTH-1:0] eres;
        int w;
        int hold;
        for (int it = 0; it < 40; it++) begin
            m = 4'($urandom);
            req_op = 8'($urandom); req_a = $urandom; req_b = $urandom;
            rsp_ready = 1'($urandom);
            req_valid = m;
            #1;
            w = exp_winner(m, model_last);
            if (w < 0) begin
                checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rnd%0d_idle_ready got=%b exp=0000", it, req_ready); end
                tick();
                checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rnd%0d_idle_valid got=%b exp=0", it, rsp_valid); end
                continue;
            end
            checks++; if (req_ready !== 4'(1 << w)) begin errors++; $display("FAIL rnd%0d_grant got=%b mask=%b exp_idx=%0d", it, req_ready, m, w); end
            eres = exp_fn(req_op[2*w +: 2], req_a[WIDTH*w +: WIDTH], req_b[WIDTH*w +: WIDTH]);
            model_last = w;
            tick();
            req_op = 8'($urandom); req_a = $urandom; req_b = $urandom;
            #1;
            checks++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin
                errors++; $display("FAIL rnd%0d_exec got rdy=%b v=%b exp rdy=0000 v=0", it, req_ready, rsp_valid); end
            tick();
            rsp_ready = 1'b0;
            hold = $urandom_range(0, 3);
            for (int h = 0; h <= hold; h++) begin
                checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(w) || rsp_data !== eres) begin
                    errors++; $display("FAIL rnd%0d_rsp got v=%b id=%0d d=%h exp v=1 id=%0d d=%h", it, rsp_valid, rsp_id, rsp_data, w, eres); end
                if (h < hold) tick();
            end
            rsp_ready = 1'b1;
            tick();
            exp_count++;
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rnd%0d_drop got=%b exp=0", it, rsp_valid); end
`ifdef LOGIC_ARB_STATS_EN
            checks++; if (op_count !== 16'(exp_count)) begin errors++; $display("FAIL rnd%0d_op_count got=%0d exp=%0d", it, op_count, exp_count); end
`endif
        end
        req_valid = '0; rsp_ready = 1'b0;
    endtask

`ifdef LOGIC_ARB_STATS_EN
    task automatic test_stats();
        rst = 1'b1; tick(); rst = 1'b0; model_last = NREQ - 1; exp_count = 0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_valid = 4'b0001; tick(); req_valid = '0; tick(); tick();
        end
        checks++; if (op_count !== 16'd3) begin errors++; $display("FAIL stats_count got=%0d exp=3", op_count); end
        rst = 1'b1; #1;
        checks++; if (op_count !== 16'd0) begin errors++; $display("FAIL stats_reset got=%0d exp=0", op_count); end
        tick(); rst = 1'b0; rsp_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_not();
        test_ops();
        test_round_robin();
        test_hold();
        test_abort();
        test_random();
`ifdef LOGIC_ARB_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
